trellis_mod: RTL and testbench
==============================

# trellis_mod

SOQPSK (MIL, rectangular frequency pulse, h = 1/2) baseband modulator: the transmit-side counterpart of the trellis demodulator. It accepts data bits through a valid/ready handshake into a small FIFO and precodes them into ternary symbols. It integrates phase at two samples per symbol and emits 18-bit I/Q on the same `symEn`/`sym2xEn` timebase the demodulator consumes. It sits between the test/data source and the DAC output mux, and serves as a loopback stimulus for the trellis path.

## Interface
- `AMP`, 18'h1FFFF, full-scale amplitude, positive two's complement
- `AMP45`, 18'h16A09, amplitude × cos(π/4), rounded
- `FIFO_DEPTH`, 4, input FIFO depth; power of two, ≥ 2
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `symEn`  in  1  symbol strobe; always coincident with a `sym2xEn` pulse
- `sym2xEn`  in  1  half-symbol (sample) strobe
- `modEnable`  in  1  1 = run, 0 = idle
- `dataIn`  in  1  data bit; 1 → +1, 0 → −1
- `dataValid`  in  1  `dataIn` valid
- `dataReady`  out  1  FIFO not full
- `pnSelect`  in  1  use the internal PN source (see Configuration)
- `iOut`  out  18  in-phase sample
- `qOut`  out  18  quadrature sample
- `outEn`  out  1  one-clock pulse marking new `iOut`/`qOut`
- `underflow`  out  1  one-clock pulse when a symbol slot finds the FIFO empty

## Operation
- FIFO:
  - A write occurs when `dataValid && dataReady`.
  - `dataReady = !full` (registered from the count).
  - A read occurs only at `symEn` in RUN with the FIFO not empty.
  - Simultaneous read and write is legal; the count is unchanged.
  - A write to an empty FIFO in the same cycle as `symEn` is not visible to that read; that slot underflows.
- States:
  - IDLE: `modEnable` = 0. Phase is forced to 0 and the FIFO is held; writes are still accepted. History is set to a[k−1] = a[k−2] = +1 and parity k = 0.
  - IDLE → RUN on the first `symEn` with `modEnable` = 1.
  - RUN → IDLE in the cycle `modEnable` is sampled 0. Phase is reset to 0 and the FIFO contents are retained.
- Precoder, evaluated at each `symEn` in RUN with a bit available:
  - α = (−1)^(k+1) · a[k−1] · (a[k] − a[k−2]) / 2, so α ∈ {−1, 0, +1}.
  - The history then shifts and k parity toggles.
- Underflow slot:
  - α = 0.
  - History and parity are unchanged.
  - `underflow` pulses.
- Phase:
  - 16-bit accumulator, 2^16 = 2π, wraps modulo 2^16.
  - At every `sym2xEn` in RUN (including the `symEn` sample): phase += α·16'h2000, using the current symbol's α.
- Mapping: phase[15:13] indexes the 8 points (cos, sin):
  - 0 → (AMP, 0)
  - 1 → (AMP45, AMP45)
  - 2 → (0, AMP)
  - 3 → (−AMP45, AMP45)
  - 4 → (−AMP, 0)
  - 5 → (−AMP45, −AMP45)
  - 6 → (0, −AMP)
  - 7 → (AMP45, −AMP45)
- Negation is two's complement. `AMP` ≤ 18'h1FFFF, so negation cannot overflow.

## Timing
- Reset values:
  - `iOut` = AMP, `qOut` = 0
  - `outEn` = 0, `underflow` = 0
  - `dataReady` = 1
  - FIFO empty, phase 0, state IDLE, k = 0, history +1/+1
- FIFO and precoder: the FIFO read and the α computation happen in the `symEn` cycle (cycle 0). `underflow` is registered and pulses in cycle 1.
- Phase: updates at the end of cycle 1, from the α registered in cycle 0.
- Outputs: `iOut`/`qOut` are registered from the updated phase in cycle 2, with `outEn` = 1 in cycle 2.
  - Sample-strobe to output latency is fixed at 2 clocks for every `sym2xEn`.
- IDLE: `outEn` still pulses 2 clocks after each `sym2xEn`, with `iOut` = AMP and `qOut` = 0.
- `dataReady` deasserts in the cycle after the write that fills the FIFO.
- Reset mid-operation: in-flight samples are discarded. The FIFO is flushed and no `outEn` pulse follows.

## Configuration
- `TRELLIS_MOD_PN_EN` defined:
  - Builds a PN15 generator (x^15 + x^14 + 1, seeded all ones), advanced once per RUN `symEn` while `pnSelect` = 1.
  - When `pnSelect` = 1 the PN bit replaces the FIFO bit. The FIFO is not read and `underflow` never pulses.
- `TRELLIS_MOD_PN_EN` undefined: `pnSelect` is present but ignored, and no PN logic is built.

## Test plan
- Reset, `modEnable` = 0, `sym2xEn` every 4 clocks → `dataReady` = 1; every `outEn` shows `iOut` = 18'h1FFFF, `qOut` = 0.
- Enable, write the single bit 0, then supply nothing more → symbol 0 has α = +1. The next two `outEn` pulses show (18'h16A09, 18'h16A09) then (0, 18'h1FFFF). The next `symEn` pulses `underflow` and the phase holds at (0, 18'h1FFFF).
- Enable with a continuous stream of 1s → α = 0 on every symbol; output stays (18'h1FFFF, 0) and `underflow` never pulses.
- Fill the FIFO with `modEnable` = 0 → `dataReady` goes 0 after 4 writes; a 5th `dataValid` is not accepted. After enable, one bit drains per `symEn` and `dataReady` returns to 1.
- Assert `reset` mid-stream → the next cycle shows the reset values; no `outEn` appears until the next `sym2xEn` + 2.
- With `TRELLIS_MOD_PN_EN`, `pnSelect` = 1, FIFO empty → no `underflow`; the recovered bit sequence matches PN15 from the all-ones seed.

Source files
------------

// File: rtl/trellis_mod.sv
// SOQPSK-MIL (h=1/2, rectangular pulse) modulator: bit FIFO -> ternary precoder -> phase accumulator -> 8-point I/Q map.
// Latency 2 clocks from every sym2xEn to outEn; dataReady drops when the FIFO is full. Optional PN15 source: TRELLIS_MOD_PN_EN.
module trellis_mod #(
  parameter logic [17:0] AMP        = 18'h1FFFF,
  parameter logic [17:0] AMP45      = 18'h16A09,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        symEn,
  input  logic        sym2xEn,
  input  logic        modEnable,
  input  logic        dataIn,
  input  logic        dataValid,
  output logic        dataReady,
  input  logic        pnSelect,
  output logic [17:0] iOut,
  output logic [17:0] qOut,
  output logic        outEn,
  output logic        underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;
  logic   active;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The enabling symEn already counts as a RUN symbol slot.
  always_comb begin
    state_nxt = state;
    active    = 1'b0;
    case (state)
      IDLE: if (modEnable && symEn) begin
        state_nxt = RUN;
        active    = 1'b1;
      end
      RUN: if (!modEnable) state_nxt = IDLE;
           else            active    = 1'b1;
    endcase
  end

  logic sym_slot;
  assign sym_slot = active && symEn;

  logic use_pn;
  logic pn_bit;
`ifdef TRELLIS_MOD_PN_EN
  logic [14:0] pn;
  always_ff @(posedge clk) begin
    if (reset)                     pn <= '1;
    else if (sym_slot && pnSelect) pn <= {pn[13:0], pn[14] ^ pn[13]};
  end
  assign use_pn = pnSelect;
  assign pn_bit = pn[14];
`else
  logic unused_pn;
  assign unused_pn = pnSelect;
  assign use_pn    = 1'b0;
  assign pn_bit    = 1'b0;
`endif

  logic [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count, count_nxt;
  logic                  do_wr, do_rd, have_bit, bit_val;

  assign do_wr     = dataValid && dataReady;
  assign do_rd     = sym_slot && !use_pn && (count != '0);
  assign count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  assign have_bit  = use_pn || (count != '0);
  assign bit_val   = use_pn ? pn_bit : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= dataIn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dataReady <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      dataReady <= (count_nxt != FULL_CNT);
    end
  end

  // Bits are kept as 1 = +1, 0 = -1. alpha is nonzero only when a[k] != a[k-2];
  // its sign is negative for an odd count of {a[k]<0, a[k-1]<0, k even}.
  logic       h1, h2, kpar;
  logic [1:0] alpha_q, alpha_nxt;

  always_comb begin
    alpha_nxt = 2'b00;
    if (bit_val != h2) alpha_nxt = ((~bit_val) ^ (~h1) ^ (~kpar)) ? 2'b11 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h1        <= 1'b1;
      h2        <= 1'b1;
      kpar      <= 1'b0;
      alpha_q   <= 2'b00;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (!modEnable) begin
        h1      <= 1'b1;
        h2      <= 1'b1;
        kpar    <= 1'b0;
        alpha_q <= 2'b00;
      end else if (sym_slot) begin
        if (have_bit) begin
          h2      <= h1;
          h1      <= bit_val;
          kpar    <= ~kpar;
          alpha_q <= alpha_nxt;
        end else begin
          alpha_q   <= 2'b00;
          underflow <= 1'b1;
        end
      end
    end
  end

  logic [15:0] phase, phase_nxt, phase_step;
  logic        s2x_d1, adv_d1;

  always_comb begin
    phase_step = 16'h0000;
    case (alpha_q)
      2'b01:   phase_step = 16'h2000;
      2'b11:   phase_step = 16'hE000;
      default: phase_step = 16'h0000;
    endcase
  end

  assign phase_nxt = !modEnable ? 16'h0000 :
                     adv_d1     ? phase + phase_step : phase;

  logic [17:0] lut_i, lut_q;
  always_comb begin
    lut_i = AMP;
    lut_q = 18'h0;
    case (phase_nxt[15:13])
      3'd0: begin lut_i = AMP;     lut_q = 18'h0;   end
      3'd1: begin lut_i = AMP45;   lut_q = AMP45;   end
      3'd2: begin lut_i = 18'h0;   lut_q = AMP;     end
      3'd3: begin lut_i = -AMP45;  lut_q = AMP45;   end
      3'd4: begin lut_i = -AMP;    lut_q = 18'h0;   end
      3'd5: begin lut_i = -AMP45;  lut_q = -AMP45;  end
      3'd6: begin lut_i = 18'h0;   lut_q = -AMP;    end
      3'd7: begin lut_i = AMP45;   lut_q = -AMP45;  end
    endcase
  end

  // Phase and output map update together so each sample lands 2 clocks after its strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2x_d1 <= 1'b0;
      adv_d1 <= 1'b0;
      phase  <= 16'h0000;
      outEn  <= 1'b0;
      iOut   <= AMP;
      qOut   <= 18'h0;
    end else begin
      s2x_d1 <= sym2xEn;
      adv_d1 <= sym2xEn && active;
      phase  <= phase_nxt;
      outEn  <= s2x_d1;
      if (s2x_d1) begin
        iOut <= lut_i;
        qOut <= lut_q;
      end
    end
  end

endmodule

// File: tb/tb_trellis_mod.sv
// Self-checking bench for trellis_mod: per-cycle behavioural model plus literal anchors for the directed scenarios.
module tb_trellis_mod;

  localparam logic [17:0] AMP   = 18'h1FFFF;
  localparam logic [17:0] AMP45 = 18'h16A09;
  localparam int NC = 4000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, symEn = 1'b0, sym2xEn = 1'b0, modEnable = 1'b0;
  logic        dataIn = 1'b0, dataValid = 1'b0, pnSelect = 1'b0;
  logic        dataReady, outEn, underflow;
  logic [17:0] iOut, qOut;

  trellis_mod dut (
    .clk(clk), .reset(reset), .symEn(symEn), .sym2xEn(sym2xEn), .modEnable(modEnable),
    .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady), .pnSelect(pnSelect),
    .iOut(iOut), .qOut(qOut), .outEn(outEn), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // model state and per-cycle expectations
  bit          exp_oe [NC+4];
  bit          exp_und[NC+4];
  logic [17:0] exp_i  [NC+4];
  logic [17:0] exp_q  [NC+4];
  bit          m_valid = 1'b0, m_rst_prev = 1'b0, m_run = 1'b0;
  bit          m_fifo[$];
  int          m_phase = 0, m_alpha = 0, m_k = 0, m_a1 = 1, m_a2 = 1;

  logic [17:0] obs_i[$], obs_q[$];
  int          und_cnt = 0;
  logic        s_rdy;

  task automatic cmp1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, expv);
    end
  endtask

  task automatic cmp18(input string name, input logic [17:0] act, input logic [17:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, expv);
    end
  endtask

  task automatic cmpi(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, expv);
    end
  endtask

  function automatic void map_pt(input int ph, output logic [17:0] i, output logic [17:0] q);
    int octant = ph / 8192;
    i = AMP; q = 18'h0;
    case (octant)
      0: begin i = AMP;    q = 18'h0;   end
      1: begin i = AMP45;  q = AMP45;   end
      2: begin i = 18'h0;  q = AMP;     end
      3: begin i = -AMP45; q = AMP45;   end
      4: begin i = -AMP;   q = 18'h0;   end
      5: begin i = -AMP45; q = -AMP45;  end
      6: begin i = 18'h0;  q = -AMP;    end
      default: begin i = AMP45; q = -AMP45; end
    endcase
  endfunction

  task automatic check_cycle();
    if (!m_valid) return;
    cmp1("dataReady", dataReady, m_fifo.size() != 4);
    cmp1("underflow", underflow, exp_und[cyc]);
    cmp1("outEn", outEn, exp_oe[cyc]);
    if (exp_oe[cyc] && outEn) begin
      cmp18("iOut", iOut, exp_i[cyc]);
      cmp18("qOut", qOut, exp_q[cyc]);
    end
    if (m_rst_prev) begin
      cmp18("rst_iOut", iOut, 18'h1FFFF);
      cmp18("rst_qOut", qOut, 18'h0);
      cmp1("rst_dataReady", dataReady, 1'b1);
    end
    if (outEn) begin
      obs_i.push_back(iOut);
      obs_q.push_back(qOut);
    end
    if (underflow) und_cnt++;
    s_rdy = dataReady;
  endtask

  task automatic model_step();
    bit rdy, act;
    int a, sgn;
    rdy = (m_fifo.size() != 4);
    if (reset) begin
      m_fifo.delete();
      m_phase = 0; m_run = 0; m_alpha = 0; m_k = 0; m_a1 = 1; m_a2 = 1;
      exp_und[cyc+1] = 0;
      exp_oe[cyc+1]  = 0;
      m_valid = 1; m_rst_prev = 1;
      return;
    end
    m_rst_prev = 0;
    act = 0;
    if (!modEnable) begin
      m_run = 0; m_phase = 0; m_alpha = 0; m_k = 0; m_a1 = 1; m_a2 = 1;
    end else if (m_run || symEn) begin
      m_run = 1; act = 1;
    end
    if (act && symEn) begin
      if (m_fifo.size() > 0) begin
        a   = m_fifo.pop_front() ? 1 : -1;
        sgn = (m_k % 2 == 0) ? -1 : 1;
        m_alpha = sgn * m_a1 * (a - m_a2) / 2;
        m_a2 = m_a1; m_a1 = a; m_k++;
      end else begin
        m_alpha = 0;
        exp_und[cyc+1] = 1;
      end
    end
    if (dataValid && rdy) m_fifo.push_back(dataIn);
    if (sym2xEn) begin
      if (act) m_phase = (m_phase + m_alpha * 8192 + 65536) % 65536;
      exp_oe[cyc+2] = 1;
      map_pt(m_phase, exp_i[cyc+2], exp_q[cyc+2]);
    end
  endtask

  task automatic tick(input bit r, input bit me, input bit dv, input bit di);
    @(negedge clk);
    if (cyc >= NC) begin
      $display("FAIL cycle_budget cyc=%0d", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    check_cycle();
    reset = r; modEnable = me; dataValid = dv; dataIn = di;
    sym2xEn = (cyc % 4 == 0);
    symEn   = (cyc % 8 == 0);
    model_step();
    cyc++;
  endtask

  task automatic clear_obs();
    obs_i.delete(); obs_q.delete(); und_cnt = 0;
  endtask

  task automatic align_idle();
    while (cyc % 8 != 6) tick(0, 0, 0, 0);
  endtask

  int bad;
  bit me_r;
  int dv_pct;

  initial begin
    // reset, then idle with strobes
    repeat (3) tick(1, 0, 0, 0);
    clear_obs();
    repeat (24) tick(0, 0, 0, 0);
    bad = 0;
    foreach (obs_i[n]) if (obs_i[n] !== AMP || obs_q[n] !== 18'h0) bad++;
    cmpi("idle_points_bad", bad, 0);
    cmp1("idle_oe_seen", obs_i.size() >= 5, 1'b1);

    // single bit 0, then starve
    repeat (2) tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    align_idle();
    tick(0, 1, 0, 0);
    clear_obs();
    repeat (19) tick(0, 1, 0, 0);
    cmpi("dir_obs_count", obs_i.size(), 4);
    if (obs_i.size() >= 4) begin
      cmp18("dir_i0", obs_i[0], 18'h16A09); cmp18("dir_q0", obs_q[0], 18'h16A09);
      cmp18("dir_i1", obs_i[1], 18'h0);     cmp18("dir_q1", obs_q[1], 18'h1FFFF);
      cmp18("dir_i2", obs_i[2], 18'h0);     cmp18("dir_q2", obs_q[2], 18'h1FFFF);
      cmp18("dir_i3", obs_i[3], 18'h0);     cmp18("dir_q3", obs_q[3], 18'h1FFFF);
    end
    cmpi("dir_underflows", und_cnt, 2);

    // continuous ones
    repeat (2) tick(1, 0, 0, 0);
    align_idle();
    tick(0, 1, 1, 1);
    clear_obs();
    repeat (40) tick(0, 1, 1, 1);
    bad = 0;
    foreach (obs_i[n]) if (obs_i[n] !== AMP || obs_q[n] !== 18'h0) bad++;
    cmpi("ones_points_bad", bad, 0);
    cmpi("ones_underflows", und_cnt, 0);
    cmp1("ones_oe_seen", obs_i.size() >= 8, 1'b1);

    // fill while idle, then drain
    repeat (2) tick(1, 0, 0, 0);
    repeat (5) tick(0, 0, 1, $urandom_range(0, 1) == 1);
    tick(0, 0, 0, 0);
    cmp1("fill_ready_low", s_rdy, 1'b0);
    align_idle();
    tick(0, 1, 0, 0);
    clear_obs();
    repeat (39) tick(0, 1, 0, 0);
    cmpi("drain_underflows", und_cnt, 1);
    cmp1("drain_ready_high", s_rdy, 1'b1);

    // randomized traffic with enable toggles and occasional resets
    repeat (2) tick(1, 0, 0, 0);
    me_r = 1'b0;
    dv_pct = 50;
    for (int n = 0; n < 2500; n++) begin
      if (n % 500 == 0) dv_pct = (n / 500 % 3 == 0) ? 8 : (n / 500 % 3 == 1) ? 40 : 100;
      if (cyc % 8 == 6 && $urandom_range(0, 11) == 0) me_r = ~me_r;
      tick($urandom_range(0, 299) == 0, me_r, $urandom_range(0, 99) < dv_pct,
           $urandom_range(0, 1) == 1);
    end
    repeat (4) tick(0, me_r, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
